seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares the single hex-to-7-segment decoder across NUM_DIGITS common-anode digits. It holds a double-buffered display image and steps one digit per slot. For each slot it presents that digit's nibble to the decoder and drives one active-low digit select, with a blanking guard between digits to suppress ghosting. It sits between the user/datapath registers and the existing combinational segment decoder on the board display.

---
 rtl/seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits.
// Double-buffered image, one digit per slot, blanking guard at the start of every slot.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    output logic [3:0]              nib,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DIV_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           div_cnt_q, div_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic [4*NUM_DIGITS-1:0] shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]   shd_en_q, shd_en_d;

    logic slot_end;
    logic frame_end;

    // Slot timing, digit index and blank/show sequencing.
    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        idx_d     = idx_q;
        state_d   = state_q;
        slot_end  = (div_cnt_q == DIV_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        if (slot_end) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        unique case (state_q)
            BLANK: if (div_cnt_q == BLANK_LAST) state_d = SHOW;
            SHOW:  if (slot_end) state_d = BLANK;
            default: state_d = BLANK;
        endcase
        frame_tick_d = frame_end;
    end

    // Pending buffer takes every load; shadow is swapped in only at frame boundaries
    // so a frame is always drawn from one consistent image.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_en_d  = pend_en_q;
        shd_val_d  = shd_val_q;
        shd_dp_d   = shd_dp_q;
        shd_en_d   = shd_en_q;
        if (frame_end) begin
            shd_val_d = pend_val_q;
            shd_dp_d  = pend_dp_q;
            shd_en_d  = pend_en_q;
        end
        if (load) begin
            pend_val_d = value_in;
            pend_dp_d  = dp_in;
            pend_en_d  = en_in;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BLANK;
            div_cnt_q    <= '0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            shd_val_q    <= '0;
            shd_dp_q     <= '0;
            shd_en_q     <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            frame_tick_q <= frame_tick_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            shd_val_q    <= shd_val_d;
            shd_dp_q     <= shd_dp_d;
            shd_en_q     <= shd_en_d;
        end
    end

    // Display drive: nibble presented through blanking so the decoder settles early.
    always_comb begin
        nib        = shd_val_q[{idx_q, 2'b00} +: 4];
        dp_n       = !((state_q == SHOW) && shd_dp_q[idx_q]);
        frame_tick = frame_tick_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_sel[i] = !((state_q == SHOW) && (idx_q == IW'(i)) && shd_en_q[i]);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed stimulus against a cycle-count
// reference model of the scan controller (4 digits, 8-cycle slots, 2 blank).
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int F = N * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic [3:0]  nib;
    logic [3:0]  dig_sel;
    logic        dp_n;
    logic        frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value_in(value_in),
        .dp_in(dp_in),
        .en_in(en_in),
        .nib(nib),
        .dig_sel(dig_sel),
        .dp_n(dp_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: t = cycles since reset release.
    int          t = 0;
    logic [15:0] m_pval = '0;
    logic [3:0]  m_pdp = '0;
    logic [3:0]  m_pen = '0;
    logic [15:0] m_sval = '0;
    logic [3:0]  m_sdp = '0;
    logic [3:0]  m_sen = '0;
    logic        m_tick = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_outs();
        int         idx;
        int         pos;
        bit         show;
        logic [3:0] edig;
        idx  = (t / R) % N;
        pos  = t % R;
        show = (pos >= B);
        edig = 4'hF;
        if (show && m_sen[idx]) edig[idx] = 1'b0;
        chk("nib", nib, m_sval[4*idx +: 4]);
        chk("dig_sel", dig_sel, edig);
        chk("dp_n", dp_n, !(show && m_sdp[idx]));
        chk("frame_tick", frame_tick, m_tick);
        chk("one_hot", ($countones(~dig_sel) <= 1), 1'b1);
    endtask

    task automatic cyc(input logic l, input logic [15:0] v,
                       input logic [3:0] d, input logic [3:0] e);
        load     = l;
        value_in = v;
        dp_in    = d;
        en_in    = e;
        @(posedge clk);
        if (t % F == F - 1) begin
            m_sval = m_pval;
            m_sdp  = m_pdp;
            m_sen  = m_pen;
            m_tick = 1'b1;
        end else begin
            m_tick = 1'b0;
        end
        if (l) begin
            m_pval = v;
            m_pdp  = d;
            m_pen  = e;
        end
        t++;
        #1;
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_to(input int ph);
        while (t % F != ph) cyc(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic model_reset();
        t      = 0;
        m_pval = '0;
        m_pdp  = '0;
        m_pen  = '0;
        m_sval = '0;
        m_sdp  = '0;
        m_sen  = '0;
        m_tick = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_dig", dig_sel, 4'hF);
        chk("rst_dp", dp_n, 1'b1);
        chk("rst_nib", nib, 4'h0);
        chk("rst_tick", frame_tick, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Load at cycle 3: frame 0 dark, frame 1 shows 1,2,3,4.
        idle(3);
        cyc(1'b1, 16'h4321, 4'b0100, 4'b1111);
        idle_to(0);
        idle(F);
        idle_to(0);

        // Partially enabled image.
        cyc(1'b1, 16'h9876, 4'b1111, 4'b1010);
        idle(3 * F);
        idle_to(0);

        // Last load in a frame wins.
        idle(10);
        cyc(1'b1, 16'hAAAA, 4'b0011, 4'b1111);
        idle(9);
        cyc(1'b1, 16'hBBBB, 4'b1000, 4'b1111);
        idle(2 * F);

        // Load on the boundary edge goes one frame later.
        idle_to(5);
        cyc(1'b1, 16'hDDDD, 4'b0001, 4'b1111);
        idle_to(F - 1);
        cyc(1'b1, 16'hCCCC, 4'b0110, 4'b1111);
        idle(3 * F);

        // Load held high with changing data.
        for (int i = 0; i < 2 * F + 7; i++)
            cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
        idle(F);

        // Random loads over ten frames.
        for (int i = 0; i < 10 * F; i++) begin
            if ($urandom_range(0, 7) == 0)
                cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                idle(1);
        end

        // Asynchronous reset during digit 2 show cycles.
        cyc(1'b1, 16'h5A5A, 4'b1111, 4'b1111);
        idle(F);
        idle_to(2 * R + 4);
        chk("pre_rst_dig", dig_sel, 4'b1011);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dig", dig_sel, 4'hF);
        chk("arst_dp", dp_n, 1'b1);
        chk("arst_nib", nib, 4'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_dig", dig_sel, 4'hF);
        chk("arst_hold_tick", frame_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outs();
        cyc(1'b1, 16'h1357, 4'b0010, 4'b1101);
        idle(3 * F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
